// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and count width for pipe_stage_reg
package pipe_pkg;

    localparam int PIPE_CNT_W = 2;

    // Encoded so that the state value equals the number of beats held
    typedef enum logic [PIPE_CNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_register_nbit.sv
// register_nbit: WIDTH-bit enabled register with async active-low reset to RESET_VAL
module register_nbit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             enable,
    input  logic             reset
);

    // Load d only when enabled, otherwise hold
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= RESET_VAL;
        else if (enable) q <= d;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register stage.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid version with a registered in_ready;
// without it the stage holds one beat and in_ready is combinational.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t      state, state_nx;
    logic             accept, emit, main_en;
    logic [WIDTH-1:0] main_d;

    assign out_valid = state != EMPTY;
    assign count     = PIPE_CNT_W'(state);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_en;
    logic [WIDTH-1:0] skid_q, skid_d;

    assign skid_d = flush ? RESET_VAL : in_data;

    // Next state and register enables; flush overrides every other event
    always_comb begin
        state_nx = state;
        main_en  = 1'b0;
        main_d   = in_data;
        skid_en  = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            main_en  = 1'b1;
            main_d   = RESET_VAL;
            skid_en  = 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = ONE;
                    main_en  = 1'b1;
                end
                ONE: if (accept && emit) begin
                    main_en  = 1'b1;
                end else if (accept) begin
                    state_nx = TWO;
                    skid_en  = 1'b1;
                end else if (emit) begin
                    state_nx = EMPTY;
                end
                TWO: if (emit) begin
                    state_nx = ONE;
                    main_en  = 1'b1;
                    main_d   = skid_q;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge reset)
        if (!reset) in_ready <= 1'b0;
        else in_ready <= state_nx != TWO;

    register_nbit #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .q      (skid_q),
        .d      (skid_d),
        .clk    (clk),
        .enable (skid_en),
        .reset  (reset)
    );
`else
    logic alive;

    // Without a skid entry a held beat can only be replaced when it leaves this cycle
    assign in_ready = alive & (~out_valid | out_ready);

    // Next state and register enables; flush overrides every other event
    always_comb begin
        state_nx = state;
        main_en  = 1'b0;
        main_d   = in_data;
        if (flush) begin
            state_nx = EMPTY;
            main_en  = 1'b1;
            main_d   = RESET_VAL;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx = ONE;
                    main_en  = 1'b1;
                end
                ONE: if (accept) begin
                    main_en  = 1'b1;
                end else if (emit) begin
                    state_nx = EMPTY;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Holds in_ready low during reset and until the first edge after release
    always_ff @(posedge clk or negedge reset)
        if (!reset) alive <= 1'b0;
        else alive <= 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= EMPTY;
        else state <= state_nx;

    register_nbit #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .q      (out_data),
        .d      (main_d),
        .clk    (clk),
        .enable (main_en),
        .reset  (reset)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  count;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    logic [31:0] last = '0;
    logic        rdy_reg = 1'b0;
    logic        alive = 1'b0;

    pipe_stage_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
`ifdef PIPE_STAGE_SKID_EN
        return rdy_reg;
`else
        return alive & ((q.size() == 0) | out_ready);
`endif
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready()));
        chk({tag, ".out_data"}, 64'(out_data), 64'(last));
    endtask

    task automatic model_reset();
        q.delete();
        last = '0;
        rdy_reg = 1'b0;
        alive = 1'b0;
    endtask

    task automatic step(input string tag, input logic f, input logic v, input logic [31:0] d, input logic o);
        logic acc, em;
        @(negedge clk);
        flush = f; in_valid = v; in_data = d; out_ready = o;
        #1;
        chk_all(tag);
        acc = v & m_ready();
        em  = (q.size() != 0) & o;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (em) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        last = f ? 32'h0 : (q.size() != 0 ? q[0] : last);
        rdy_reg = q.size() < 2;
        alive = 1'b1;
    endtask

    initial begin
        // Reset with a beat offered: nothing may be captured
        #1 reset = 1'b0;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_all("reset_hold");
        reset = 1'b1;
        in_valid = 1'b0;
        #1 chk("pre_edge.in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); alive = 1'b1; rdy_reg = 1'b1;
        #1 chk("post_release.in_ready", 64'(in_ready), 64'h1);

        // Streaming with out_ready high
        step("s1", 0, 1, 32'd1, 1);
        step("s2", 0, 1, 32'd2, 1);
        step("s3", 0, 1, 32'd3, 1);
        step("s4", 0, 0, 32'd0, 1);
        step("s5", 0, 0, 32'd0, 1);

        // Backpressure: A then B, then drain
        step("bp1", 0, 1, 32'hA, 0);
        step("bp2", 0, 1, 32'hB, 0);
        step("bp3", 0, 0, 32'h0, 0);
        step("bp4", 0, 0, 32'h0, 1);
        step("bp5", 0, 0, 32'h0, 1);
        step("bp6", 0, 0, 32'h0, 1);

        // Held beat replaced in the same cycle it leaves
        step("rp1", 0, 1, 32'h5, 0);
        step("rp2", 0, 1, 32'h6, 0);
        step("rp3", 0, 1, 32'h7, 1);
        step("rp4", 0, 0, 32'h0, 1);
        step("rp5", 0, 0, 32'h0, 0);

        // Flush while full with a beat offered
        step("fl1", 0, 1, 32'h1111, 0);
        step("fl2", 0, 1, 32'h2222, 0);
        step("fl3", 1, 1, 32'hC, 1);
        step("fl4", 0, 0, 32'h0, 1);
        step("fl5", 0, 0, 32'h0, 1);

        // Async reset in the middle of a cycle while holding beats
        step("ar1", 0, 1, 32'h3333, 0);
        step("ar2", 0, 1, 32'h4444, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1 chk_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); alive = 1'b1; rdy_reg = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++)
            step("rnd", ($urandom_range(0, 19) == 0), 1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 4; i++)
            step("drain", 0, 0, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..64).
REQ-002 SHALL have parameter RESET_VAL, default '0, value loaded into data registers on reset and flush.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  payload, driven directly from main register.
REQ-012 SHALL have port count  output  2  beats held (0..2).

Function
REQ-013 SHALL define accept = in_valid & in_ready and emit = out_valid & out_ready, both sampled at the rising edge.
REQ-014 SHALL update data registers only on accept or on transfer from skid to main; otherwise hold (enable semantics).
REQ-015 SHALL give 1-cycle latency: a beat accepted at edge N is on out_data with out_valid=1 after edge N.
REQ-016 SHALL implement states EMPTY (count=0), ONE (count=1), TWO (count=2); out_valid = (state != EMPTY).
REQ-017 EMPTY: accept -> ONE, main <= in_data.
REQ-018 ONE: accept & emit -> ONE, main <= in_data; accept & !emit -> TWO, skid <= in_data; !accept & emit -> EMPTY; neither -> hold.
REQ-019 TWO: emit -> ONE, main <= skid; !emit -> hold; in_ready=0, so no accept is possible.
REQ-020 SHALL drive in_ready from a register: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-021 SHALL preserve beat order; no beat is duplicated or dropped except by flush or reset.
REQ-022 flush=1 SHALL win over all other events: next state EMPTY, main and skid <= RESET_VAL, in_ready=1; a beat offered in the flush cycle is discarded.
REQ-023 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-024 While reset=0: state EMPTY, count=0, out_valid=0, in_ready=0, main and skid = RESET_VAL, independent of clk.
REQ-025 in_ready SHALL rise to 1 at the first rising edge after reset deasserts; reset mid-transfer discards all held beats.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN defined: 2-entry skid behaviour per REQ-016..REQ-020.
REQ-027 Macro absent: no skid register; states EMPTY and ONE only; in_ready = !out_valid | out_ready (combinational); count max 1; all other requirements unchanged.

Structure
REQ-028 Package pipe_pkg SHALL hold typedef enum pipe_state_t {EMPTY, ONE, TWO} and localparam PIPE_CNT_W = 2.
REQ-029 Main and skid storage SHALL each be one instance of sub-module register_nbit (parameter WIDTH, ports q, d, clk, enable, reset with async active-low reset to RESET_VAL).
REQ-030 FSM and in_ready register SHALL live in pipe_stage_reg.

Verification
REQ-031 Reset: reset=0 with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, count=0, out_data=0; after release in_ready=1 at next edge.
REQ-032 Streaming: out_ready=1, beats 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, count stays 1.
REQ-033 Backpressure (SKID_EN): out_ready=0, send 32'hA then 32'hB -> count=2, in_ready=0, out_data=32'hA held; out_ready=1 -> A then B emitted, count 2->1->0.
REQ-034 Flush: count=2, flush=1 with in_valid=1, in_data=32'hC -> next cycle count=0, out_valid=0, 32'hC never emitted.
REQ-035 Macro absent: out_ready=0, one beat held -> in_ready=0; same cycle out_ready=1 -> in_ready=1 and new beat replaces old at edge.
REQ-036 Async reset at count=2 mid-cycle -> outputs reach reset values before next clk edge.
